// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_pkg
//  Description : Shared op codes, sequencer states, cycle defaults and small
//                decode helpers for the multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    // MDU op codes as presented by the E-stage decoder
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MADD  = 3'd7
    } mdu_op_e;

    // Sequencer states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    // Default busy lengths; the down-counter is 4 bits so both must be 1..15
    localparam int unsigned c_mult_cycles = 5;
    localparam int unsigned c_div_cycles  = 10;
    localparam int unsigned c_cnt_w       = 4;

    // Ops that occupy the unit for several cycles and write both HI and LO
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    // Ops that use the divide latency
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational datapath of the MDU. Produces the full 64-bit
//                {HI,LO} result for the selected op and flags divide-by-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_b_safe;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    // Products, and divides done on magnitudes so that the most negative
    // dividend over -1 wraps cleanly instead of overflowing a signed divide
    always_comb begin
        w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        w_prod_u = {32'd0, a} * {32'd0, b};

        // A zero divisor is replaced so the divider never sees it; the
        // result is discarded by the sequencer via div0 anyway.
        w_b_safe = (b == 32'd0) ? 32'd1 : b;
        w_a_mag  = a[31] ? (32'd0 - a) : a;
        w_b_mag  = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;

        w_sq_mag = w_a_mag / w_b_mag;
        w_sr_mag = w_a_mag % w_b_mag;
        w_sq     = (a[31] ^ b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
        w_sr     = a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

        w_uq     = a / w_b_safe;
        w_ur     = a % w_b_safe;
    end

    // Result select; HI carries remainder and LO quotient for divides
    always_comb begin
        result = 64'd0;
        div0   = 1'b0;
        case (op)
            OP_MULT:  result = w_prod_s;
            OP_MULTU: result = w_prod_u;
            OP_MADD:  result = {hi, lo} + w_prod_s;
            OP_DIV: begin
                result = {w_sr, w_sq};
                div0   = (b == 32'd0);
            end
            OP_DIVU: begin
                result = {w_ur, w_uq};
                div0   = (b == 32'd0);
            end
            default:  result = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multiply/divide unit sequencer. Latches the arithmetic
//                result at issue, holds busy for a fixed latency, then
//                commits into the architectural HI/LO registers. Generates
//                the pipeline stall for HI/LO consumers in ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = c_mult_cycles,
    parameter int unsigned DIV_CYCLES  = c_div_cycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        id_hilo,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);

    mdu_state_e          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [63:0]         r_pend;
    logic                r_div0;
    logic                r_busy;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    logic [63:0]         w_result;
    logic                w_div0;

    mdu_arith u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (r_hi),
        .lo     (r_lo),
        .result (w_result),
        .div0   (w_div0)
    );

    // Sequencer: issue and latch in IDLE, count down and commit in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_div0  <= 1'b0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (is_long_op(op)) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_cnt   <= is_div_op(op) ? c_div_load : c_mult_load;
                            r_pend  <= w_result;
                            r_div0  <= w_div0;
                        end else if (op == OP_MTHI) begin
                            r_hi <= a;
                        end else if (op == OP_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    // New issues are ignored here; only the counter moves
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (!r_div0) begin
                            r_hi <= r_pend[63:32];
                            r_lo <= r_pend[31:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stall must see a long op in the issue cycle itself, hence combinational
    always_comb begin
        stall = id_hilo & (r_busy | (start & is_long_op(op)));
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for MULT, MULTU and MADD.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for DIV and DIVU.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  E-stage instruction issues an MDU op this cycle.
REQ-006 op  input  3  op code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7.
REQ-007 a  input  32  rs operand.
REQ-008 b  input  32  rt operand.
REQ-009 id_hilo  input  1  the ID-stage instruction uses HI/LO (IF/ID hi_lo flag).
REQ-010 busy  output  1  multi-cycle op in progress.
REQ-011 stall  output  1  freeze PC and IF/ID, and bubble into E.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.

Function
REQ-014 States: IDLE and RUN; the cycle counter is a 4-bit down-counter.
REQ-015 In IDLE, start with op MULT/MULTU/MADD/DIV/DIVU moves to RUN on the next edge.
- At that edge, load counter = MULT_CYCLES or DIV_CYCLES.
- At that edge, latch the full 64-bit result into pending registers.
REQ-016 busy is 1 exactly while in RUN: the issue at edge T gives busy=1 for cycles T+1 .. T+N.
REQ-017 In RUN the counter decrements each edge.
- At the edge where the counter equals 1, commit pending to {HI,LO} and return to IDLE.
- Results are visible on hi/lo in the cycle after busy falls.
REQ-018 MULT: {HI,LO} = signed a * signed b. MULTU: the same with unsigned operands.
REQ-019 MADD: {HI,LO} = {HI,LO} + signed a * signed b, modulo 2^64, using HI/LO as sampled at issue.
REQ-020 DIV: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend. DIVU: the unsigned equivalent.
REQ-021 DIV/DIVU with b=0: run the full DIV_CYCLES with busy asserted, then leave HI and LO unchanged.
REQ-022 MTHI/MTLO: with start=1 in IDLE, write a to HI/LO on the next edge; busy stays 0 and the state is unchanged.
REQ-023 start with op NONE: no effect.
REQ-024 start while in RUN is ignored; the in-flight op and the counter are unaffected.
REQ-025 stall = id_hilo AND (busy OR (start AND op in {MULT, MULTU, DIV, DIVU, MADD})). It is combinational, with no registered delay.
REQ-026 stall is 0 whenever id_hilo=0, even if busy=1.
REQ-027 hi/lo outputs are purely registered; MFHI/MFLO read them directly.

Reset
REQ-028 reset takes effect on the next edge, including mid-operation.
- State becomes IDLE; counter, pending, HI and LO become 0; busy becomes 0.
- The in-flight result is discarded.
REQ-029 While reset=1, start is ignored; stall follows REQ-025 with busy=0.

Structure
REQ-030 Op codes and cycle defaults live in a shared package/header used by the decoder.
REQ-031 One sub-module, mdu_arith, is combinational: it takes op, a, b, HI, LO and produces the 64-bit result and a div0 flag.
REQ-032 Sequencing, counter and HI/LO registers stay in mdu_ctrl.

Verification
REQ-033 MULT, a=0xFFFFFFFF, b=2 -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-034 MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-035 DIV, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, a=7, b=0 -> busy 10 cycles, HI/LO unchanged.
REQ-036 MTHI a=0x12345678, then MADD a=1, b=1 with LO=0xFFFFFFFF -> HI=0x12345679, LO=0x00000000 after 5 cycles.
REQ-037 id_hilo=1 through a DIV -> stall=1 in the issue cycle and all 10 busy cycles, then 0.
- id_hilo=0 -> stall=0 throughout.
REQ-038 reset in busy cycle 3 of a MULT -> next cycle busy=0, HI=LO=0, and no later commit.
- A new MULT issued after reset completes normally.
